// File: rtl/dsp_clk_sequencer.sv
// rtl/dsp_clk_sequencer.sv - PLL-lock sequencer producing DSP reset, 20 MHz clock enable and sample tick
//
// Purpose:
//   Holds the DSP datapath in reset until the PLL lock has been stable for
//   SETTLE_CYCLES cycles. It then produces a ce_20 enable every CE_DIV cycles
//   and a sample_tick every SAMPLE_DIV cycles. Both can be realigned by an
//   external sync pulse. Loss of lock while running forces a one-cycle FAULT
//   and sets the sticky lock_lost flag.
//
// Ports:
//   clk          200 MHz clock (PLL CLKOP)
//   rst          asynchronous active-high reset
//   pll_lock     PLL lock, asynchronous to clk
//   sync_in      external phase-alignment pulse, asynchronous
//   clr_fault    synchronous single-cycle clear of lock_lost
//   rst_dsp      registered datapath reset, active-high
//   ce_20        one-cycle enable every CE_DIV cycles while running
//   sample_tick  one-cycle tick every SAMPLE_DIV cycles, coincides with ce_20
//   sample_idx   sample_tick count since RUN entry or last sync
//   state        0 WAIT_LOCK, 1 SETTLE, 2 RUN, 3 FAULT
//   lock_lost    sticky flag: lock lost while in RUN

module dsp_clk_sequencer #(
    parameter int CE_DIV        = 10,
    parameter int SAMPLE_DIV    = 200,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_lock,
    input  logic        sync_in,
    input  logic        clr_fault,
    output logic        rst_dsp,
    output logic        ce_20,
    output logic        sample_tick,
    output logic [15:0] sample_idx,
    output logic [1:0]  state,
    output logic        lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    localparam logic [7:0]  CE_LAST     = 8'(CE_DIV - 1);
    localparam logic [15:0] SMP_LAST    = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_pipe_q;
    logic [SYNC_STAGES-1:0] sync_pipe_q;
    logic                   sync_s_d_q;

    state_t      state_q, state_d;
    logic [15:0] settle_q, settle_d;
    logic [7:0]  ce_cnt_q, ce_cnt_d;
    logic [15:0] smp_cnt_q, smp_cnt_d;
    logic [15:0] idx_q, idx_d;
    logic        rst_dsp_q, rst_dsp_d;
    logic        ce_20_q, ce_20_d;
    logic        tick_q, tick_d;
    logic        lock_lost_q, lock_lost_d;

    logic lock_s;
    logic sync_s;
    logic sync_edge;
    logic sync_edge_nx;

    assign lock_s    = lock_pipe_q[SYNC_STAGES-1];
    assign sync_s    = sync_pipe_q[SYNC_STAGES-1];
    assign sync_edge = sync_s & ~sync_s_d_q;

    // The sync edge seen in the next cycle is already visible one stage
    // earlier in the synchronizer. This lets ce_20/sample_tick stay registered
    // while still being suppressed in the cycle of the realignment edge.
    assign sync_edge_nx = sync_pipe_q[SYNC_STAGES-2] & ~sync_s;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        ce_cnt_d  = ce_cnt_q;
        smp_cnt_d = smp_cnt_q;
        idx_d     = idx_q;

        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                if (lock_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d   = RUN;
                    settle_d  = '0;
                    ce_cnt_d  = '0;
                    smp_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            RUN: begin
                // Lock loss outranks a coincident sync edge.
                if (!lock_s) begin
                    state_d   = FAULT;
                    ce_cnt_d  = '0;
                    smp_cnt_d = '0;
                    idx_d     = '0;
                end else if (sync_edge) begin
                    ce_cnt_d  = '0;
                    smp_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    ce_cnt_d  = (ce_cnt_q == CE_LAST) ? 8'd0 : ce_cnt_q + 8'd1;
                    smp_cnt_d = (smp_cnt_q == SMP_LAST) ? 16'd0 : smp_cnt_q + 16'd1;
                    // A tick in this cycle bumps the index for the next one.
                    if (smp_cnt_q == SMP_LAST) begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            FAULT: begin
                state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    always_comb begin
        rst_dsp_d = (state_d != RUN);
        ce_20_d   = (state_d == RUN) && (ce_cnt_d == CE_LAST) && !sync_edge_nx;
        tick_d    = (state_d == RUN) && (smp_cnt_d == SMP_LAST) && !sync_edge_nx;
        // Set on FAULT entry wins over a simultaneous clear.
        if (state_q == RUN && state_d == FAULT) begin
            lock_lost_d = 1'b1;
        end else if (clr_fault) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_pipe_q <= '0;
            sync_pipe_q <= '0;
            sync_s_d_q  <= 1'b0;
            state_q     <= WAIT_LOCK;
            settle_q    <= '0;
            ce_cnt_q    <= '0;
            smp_cnt_q   <= '0;
            idx_q       <= '0;
            rst_dsp_q   <= 1'b1;
            ce_20_q     <= 1'b0;
            tick_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_pipe_q <= {lock_pipe_q[SYNC_STAGES-2:0], pll_lock};
            sync_pipe_q <= {sync_pipe_q[SYNC_STAGES-2:0], sync_in};
            sync_s_d_q  <= sync_s;
            state_q     <= state_d;
            settle_q    <= settle_d;
            ce_cnt_q    <= ce_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            idx_q       <= idx_d;
            rst_dsp_q   <= rst_dsp_d;
            ce_20_q     <= ce_20_d;
            tick_q      <= tick_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign rst_dsp     = rst_dsp_q;
    assign ce_20       = ce_20_q;
    assign sample_tick = tick_q;
    assign sample_idx  = idx_q;
    assign state       = state_q;
    assign lock_lost   = lock_lost_q;

endmodule
